// File: rtl/write_buffer_merge_pkg.sv
// Shared types and default geometry for the line write buffer between the data cache and the AXI write path.
package write_buffer_merge_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } drain_state_e;

  localparam int DEF_DEPTH       = 8;
  localparam int DEF_LINE_BITS   = 256;
  localparam int DEF_ADDR_BITS   = 32;
  localparam int DEF_OFFSET_BITS = 5;

endpackage

// File: rtl/write_buffer_merge_if.sv
// CPU write/read-forward port, flush/status and memory drain signals of the write buffer.
interface write_buffer_merge_if
  import write_buffer_merge_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS
);
  localparam int STRB_BITS = LINE_BITS / 8;
  localparam int CNT_BITS  = $clog2(DEPTH) + 1;

  logic                 cpu_wreq_i;
  logic [ADDR_BITS-1:0] cpu_awaddr_i;
  logic [LINE_BITS-1:0] cpu_wdata_i;
  logic [STRB_BITS-1:0] cpu_wstrb_i;
  logic                 cpu_wready_o;
  logic                 cpu_rreq_i;
  logic [ADDR_BITS-1:0] cpu_araddr_i;
  logic                 read_hit_o;
  logic [LINE_BITS-1:0] cpu_rdata_o;
  logic [STRB_BITS-1:0] cpu_rmask_o;
  logic                 flush_i;
  logic                 idle_o;
  logic                 full_o;
  logic                 empty_o;
  logic [CNT_BITS-1:0]  count_o;
  logic                 mem_wen_o;
  logic [ADDR_BITS-1:0] mem_awaddr_o;
  logic [LINE_BITS-1:0] mem_wdata_o;
  logic [STRB_BITS-1:0] mem_wstrb_o;
  logic                 mem_bvalid_i;

  modport master (
    output cpu_wreq_i, cpu_awaddr_i, cpu_wdata_i, cpu_wstrb_i,
    output cpu_rreq_i, cpu_araddr_i, flush_i, mem_bvalid_i,
    input  cpu_wready_o, read_hit_o, cpu_rdata_o, cpu_rmask_o,
    input  idle_o, full_o, empty_o, count_o,
    input  mem_wen_o, mem_awaddr_o, mem_wdata_o, mem_wstrb_o
  );

  modport slave (
    input  cpu_wreq_i, cpu_awaddr_i, cpu_wdata_i, cpu_wstrb_i,
    input  cpu_rreq_i, cpu_araddr_i, flush_i, mem_bvalid_i,
    output cpu_wready_o, read_hit_o, cpu_rdata_o, cpu_rmask_o,
    output idle_o, full_o, empty_o, count_o,
    output mem_wen_o, mem_awaddr_o, mem_wdata_o, mem_wstrb_o
  );

endinterface

// File: rtl/write_buffer_merge_wb_line_cam.sv
// Line-address CAM over the buffer entries: one-hot hit vector plus encoded index of the match.
module wb_line_cam #(
  parameter int DEPTH    = 8,
  parameter int TAG_BITS = 27,
  parameter int IDX_BITS = 3
) (
  input  logic [DEPTH-1:0]               valid,
  input  logic [DEPTH-1:0][TAG_BITS-1:0] tags,
  input  logic [TAG_BITS-1:0]            key,
  output logic [DEPTH-1:0]               hit_vec,
  output logic [IDX_BITS-1:0]            idx
);

  // At most one entry can match, so OR-ing the matching indices encodes the one-hot vector.
  always_comb begin
    hit_vec = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tags[i] == key)) begin
        hit_vec[i] = 1'b1;
        idx        = idx | IDX_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/write_buffer_merge.sv
// Line write buffer: byte-merging FIFO of dirty lines drained in order to memory, with read forwarding.
module write_buffer_merge
  import write_buffer_merge_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int LINE_BITS   = DEF_LINE_BITS,
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input logic                clk,
  input logic                rst,
  write_buffer_merge_if.slave bus
);

  localparam int STRB_BITS = LINE_BITS / 8;
  localparam int IDX_BITS  = $clog2(DEPTH);
  localparam int CNT_BITS  = IDX_BITS + 1;
  localparam int TAG_BITS  = ADDR_BITS - OFFSET_BITS;

  drain_state_e state_q, state_nxt;

  logic [DEPTH-1:0]               valid_q;
  logic [DEPTH-1:0]               redirty_q;
  logic [DEPTH-1:0][TAG_BITS-1:0] tag_q;
  logic [LINE_BITS-1:0]           data_q [DEPTH];
  logic [STRB_BITS-1:0]           mask_q [DEPTH];
  logic [IDX_BITS-1:0]            head_q, tail_q;
  logic [CNT_BITS-1:0]            count_q;

  logic [ADDR_BITS-1:0] mem_awaddr_q;
  logic [LINE_BITS-1:0] mem_wdata_q, rdata_q;
  logic [STRB_BITS-1:0] mem_wstrb_q, rmask_q;

  logic [TAG_BITS-1:0]  w_tag, r_tag;
  logic [DEPTH-1:0]     w_hit_vec, r_hit_vec;
  logic [IDX_BITS-1:0]  w_idx, r_idx;
  logic                 w_hit, r_hit, full, empty, wready;
  logic                 wr_eff, alloc, merge_wr, head_hit, collide, keep, retire, snap;
  logic [LINE_BITS-1:0] head_data;
  logic [STRB_BITS-1:0] head_mask;
  logic                 unused_offset_bits;

  function automatic logic [LINE_BITS-1:0] byte_mask(input logic [STRB_BITS-1:0] strb);
    logic [LINE_BITS-1:0] m;
    for (int b = 0; b < STRB_BITS; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

  function automatic logic [LINE_BITS-1:0] merge_bytes(input logic [LINE_BITS-1:0] old_line,
                                                       input logic [LINE_BITS-1:0] new_line,
                                                       input logic [STRB_BITS-1:0] strb);
    logic [LINE_BITS-1:0] m;
    m = byte_mask(strb);
    return (old_line & ~m) | (new_line & m);
  endfunction

  assign w_tag = bus.cpu_awaddr_i[ADDR_BITS-1:OFFSET_BITS];
  assign r_tag = bus.cpu_araddr_i[ADDR_BITS-1:OFFSET_BITS];
  assign unused_offset_bits = ^{bus.cpu_awaddr_i[OFFSET_BITS-1:0], bus.cpu_araddr_i[OFFSET_BITS-1:0]};

  wb_line_cam #(.DEPTH(DEPTH), .TAG_BITS(TAG_BITS), .IDX_BITS(IDX_BITS)) u_wr_cam (
    .valid(valid_q), .tags(tag_q), .key(w_tag), .hit_vec(w_hit_vec), .idx(w_idx)
  );

  wb_line_cam #(.DEPTH(DEPTH), .TAG_BITS(TAG_BITS), .IDX_BITS(IDX_BITS)) u_rd_cam (
    .valid(valid_q), .tags(tag_q), .key(r_tag), .hit_vec(r_hit_vec), .idx(r_idx)
  );

  assign w_hit    = |w_hit_vec;
  assign r_hit    = |r_hit_vec;
  assign full     = (count_q == CNT_BITS'(DEPTH));
  assign empty    = (count_q == '0);
  assign wready   = !bus.flush_i && (w_hit || !full);
  assign wr_eff   = bus.cpu_wreq_i && wready && (bus.cpu_wstrb_i != '0);
  assign alloc    = wr_eff && !w_hit;
  assign merge_wr = wr_eff && w_hit;
  assign head_hit = merge_wr && (w_idx == head_q);

  // A merge into the line being sent must not be lost: keep the entry for one more pass.
  assign collide = (state_q == ST_SEND) && head_hit;
  assign keep    = redirty_q[head_q] || collide;
  assign retire  = (state_q == ST_SEND) && bus.mem_bvalid_i && !keep;
  assign snap    = (state_q == ST_IDLE) && !empty;

  // A merge landing on the snapshot edge is folded into the snapshot so memory sees it.
  assign head_data = head_hit ? merge_bytes(data_q[head_q], bus.cpu_wdata_i, bus.cpu_wstrb_i)
                              : data_q[head_q];
  assign head_mask = head_hit ? (mask_q[head_q] | bus.cpu_wstrb_i) : mask_q[head_q];

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (!empty) state_nxt = ST_SEND;
      ST_SEND: if (bus.mem_bvalid_i) state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      redirty_q    <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      mem_awaddr_q <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      rdata_q      <= '0;
      rmask_q      <= '0;
    end else begin
      if (alloc) begin
        valid_q[tail_q]   <= 1'b1;
        redirty_q[tail_q] <= 1'b0;
        tail_q            <= tail_q + IDX_BITS'(1);
      end
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + IDX_BITS'(1);
      end
      if ((state_q == ST_SEND) && bus.mem_bvalid_i) redirty_q[head_q] <= 1'b0;
      else if (collide)                             redirty_q[head_q] <= 1'b1;
      count_q <= count_q + CNT_BITS'(alloc) - CNT_BITS'(retire);
      if (snap) begin
        mem_awaddr_q <= {tag_q[head_q], {OFFSET_BITS{1'b0}}};
        mem_wdata_q  <= head_data;
        mem_wstrb_q  <= head_mask;
      end
      if (bus.cpu_rreq_i) begin
        rdata_q <= r_hit ? data_q[r_idx] : '0;
        rmask_q <= r_hit ? mask_q[r_idx] : '0;
      end
    end
  end

  // Entry payload; valid_q alone decides whether a slot means anything.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (merge_wr && w_hit_vec[i]) begin
        data_q[i] <= merge_bytes(data_q[i], bus.cpu_wdata_i, bus.cpu_wstrb_i);
        mask_q[i] <= mask_q[i] | bus.cpu_wstrb_i;
      end
      if (alloc && (tail_q == IDX_BITS'(i))) begin
        tag_q[i]  <= w_tag;
        data_q[i] <= bus.cpu_wdata_i & byte_mask(bus.cpu_wstrb_i);
        mask_q[i] <= bus.cpu_wstrb_i;
      end
    end
  end

  assign bus.cpu_wready_o = wready;
  assign bus.read_hit_o   = r_hit;
  assign bus.cpu_rdata_o  = rdata_q;
  assign bus.cpu_rmask_o  = rmask_q;
  assign bus.idle_o       = empty && (state_q == ST_IDLE);
  assign bus.full_o       = full;
  assign bus.empty_o      = empty;
  assign bus.count_o      = count_q;
  assign bus.mem_wen_o    = (state_q == ST_SEND);
  assign bus.mem_awaddr_o = mem_awaddr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;
  assign bus.mem_wstrb_o  = mem_wstrb_q;

endmodule

// File: tb/tb_write_buffer_merge.sv
// Bench for write_buffer_merge: directed scenarios plus random traffic against a queue-based line model.
module tb_write_buffer_merge;

  localparam int DEPTH       = 8;
  localparam int LINE_BITS   = 256;
  localparam int ADDR_BITS   = 32;
  localparam int OFFSET_BITS = 5;
  localparam int SB          = LINE_BITS / 8;
  localparam int TAGW        = ADDR_BITS - OFFSET_BITS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  write_buffer_merge_if #(.DEPTH(DEPTH), .LINE_BITS(LINE_BITS), .ADDR_BITS(ADDR_BITS)) bus ();

  write_buffer_merge #(
    .DEPTH(DEPTH), .LINE_BITS(LINE_BITS), .ADDR_BITS(ADDR_BITS), .OFFSET_BITS(OFFSET_BITS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  typedef struct {
    logic [TAGW-1:0]      tag;
    logic [LINE_BITS-1:0] data;
    logic [SB-1:0]        mask;
    bit                   redirty;
  } ent_t;

  // Model: FIFO of lines (index 0 = oldest), memory-side snapshot, forwarded read registers.
  ent_t                 mq[$];
  bit                   m_sending;
  bit                   model_ready = 1'b0;
  logic [ADDR_BITS-1:0] m_awaddr;
  logic [LINE_BITS-1:0] m_wdata, m_rdata;
  logic [SB-1:0]        m_wstrb, m_rmask;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [LINE_BITS-1:0] act, input logic [LINE_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int find(input logic [ADDR_BITS-1:0] a);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].tag == a[ADDR_BITS-1:OFFSET_BITS]) return i;
    return -1;
  endfunction

  function automatic bit exp_wready();
    return !bus.flush_i && ((find(bus.cpu_awaddr_i) >= 0) || (mq.size() < DEPTH));
  endfunction

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic mstep();
    int   presize, ri, wi;
    bit   acc, col;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_sending = 1'b0;
      m_awaddr = '0; m_wdata = '0; m_wstrb = '0; m_rdata = '0; m_rmask = '0;
      model_ready = 1'b1;
      return;
    end
    if (!model_ready) return;
    presize = mq.size();
    if (bus.cpu_rreq_i) begin
      ri = find(bus.cpu_araddr_i);
      if (ri >= 0) begin m_rdata = mq[ri].data; m_rmask = mq[ri].mask; end
      else begin m_rdata = '0; m_rmask = '0; end
    end
    wi  = find(bus.cpu_awaddr_i);
    acc = bus.cpu_wreq_i && exp_wready() && (bus.cpu_wstrb_i != '0);
    col = m_sending && acc && (wi == 0);
    if (acc) begin
      if (wi >= 0) e = mq[wi];
      else begin
        e.tag = bus.cpu_awaddr_i[ADDR_BITS-1:OFFSET_BITS];
        e.data = '0; e.mask = '0; e.redirty = 1'b0;
      end
      for (int b = 0; b < SB; b++)
        if (bus.cpu_wstrb_i[b]) e.data[b*8 +: 8] = bus.cpu_wdata_i[b*8 +: 8];
      e.mask = e.mask | bus.cpu_wstrb_i;
      if (wi >= 0) mq[wi] = e;
      else mq.push_back(e);
    end
    if (m_sending) begin
      if (bus.mem_bvalid_i) begin
        if (mq[0].redirty || col) mq[0].redirty = 1'b0;
        else mq.delete(0);
        m_sending = 1'b0;
      end else if (col) begin
        mq[0].redirty = 1'b1;
      end
    end else if (presize > 0) begin
      m_sending = 1'b1;
      m_awaddr  = {mq[0].tag, {OFFSET_BITS{1'b0}}};
      m_wdata   = mq[0].data;
      m_wstrb   = mq[0].mask;
    end
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      chk("count", bus.count_o, mq.size());
      chk("full", bus.full_o, mq.size() == DEPTH);
      chk("empty", bus.empty_o, mq.size() == 0);
      chk("idle", bus.idle_o, (mq.size() == 0) && !m_sending);
      chk("wready", bus.cpu_wready_o, exp_wready());
      chk("read_hit", bus.read_hit_o, find(bus.cpu_araddr_i) >= 0);
      chk("rdata", bus.cpu_rdata_o, m_rdata);
      chk("rmask", bus.cpu_rmask_o, m_rmask);
      chk("mem_wen", bus.mem_wen_o, m_sending);
      if (m_sending) begin
        chk("mem_awaddr", bus.mem_awaddr_o, m_awaddr);
        chk("mem_wdata", bus.mem_wdata_o, m_wdata);
        chk("mem_wstrb", bus.mem_wstrb_o, m_wstrb);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    mstep();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_BITS-1:0] rand_line();
    logic [LINE_BITS-1:0] v;
    for (int i = 0; i < LINE_BITS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic quiet();
    bus.cpu_wreq_i = 1'b0; bus.cpu_rreq_i = 1'b0; bus.mem_bvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_BITS-1:0] a, input logic [LINE_BITS-1:0] d, input logic [SB-1:0] s);
    bus.cpu_wreq_i = 1'b1; bus.cpu_awaddr_i = a; bus.cpu_wdata_i = d; bus.cpu_wstrb_i = s;
    step();
    bus.cpu_wreq_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if ((mq.size() == 0) && !m_sending) break;
      bus.mem_bvalid_i = m_sending;
      step();
    end
    bus.mem_bvalid_i = 1'b0;
    chk("drain_idle", bus.idle_o, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1);
  end

  initial begin
    logic [LINE_BITS-1:0] d1, d2;
    logic [ADDR_BITS-1:0] a;
    int r;
    bus.cpu_awaddr_i = '0; bus.cpu_wdata_i = '0; bus.cpu_wstrb_i = '0;
    bus.cpu_araddr_i = '0; bus.flush_i = 1'b0;
    do_reset();
    chk("rst_count", bus.count_o, 0);
    chk("rst_empty", bus.empty_o, 1);
    chk("rst_full", bus.full_o, 0);
    chk("rst_idle", bus.idle_o, 1);
    chk("rst_wready", bus.cpu_wready_o, 1);
    chk("rst_mem_wen", bus.mem_wen_o, 0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 0);
    chk("rst_rdata", bus.cpu_rdata_o, 0);

    // Single line through the buffer
    d1 = rand_line();
    wr(32'h1000, d1, '1);
    chk("t1_count", bus.count_o, 1);
    chk("t1_wen_lat", bus.mem_wen_o, 0);
    step();
    chk("t1_wen", bus.mem_wen_o, 1);
    chk("t1_awaddr", bus.mem_awaddr_o, 32'h1000);
    chk("t1_wdata", bus.mem_wdata_o, d1);
    bus.mem_bvalid_i = 1'b1;
    step();
    bus.mem_bvalid_i = 1'b0;
    chk("t1_count0", bus.count_o, 0);
    chk("t1_idle", bus.idle_o, 1);

    // Fill to full with the memory stalled
    for (int i = 0; i < DEPTH; i++) wr(32'h4000 + i * 32, rand_line(), '1);
    chk("t2_full", bus.full_o, 1);
    bus.cpu_wreq_i = 1'b1; bus.cpu_awaddr_i = 32'h5000; bus.cpu_wstrb_i = '1;
    #1 chk("t2_miss_wready", bus.cpu_wready_o, 0);
    step();
    bus.cpu_awaddr_i = 32'h4060; bus.cpu_wstrb_i = 32'h1; bus.cpu_wdata_i = rand_line();
    #1 chk("t2_hit_wready", bus.cpu_wready_o, 1);
    step();
    bus.cpu_wreq_i = 1'b0;
    chk("t2_count", bus.count_o, 8);
    drain(100);

    // Byte merge and read forwarding
    wr(32'h2000, rand_line(), 32'h0000000F);
    wr(32'h2000, rand_line(), 32'hF0000000);
    bus.cpu_rreq_i = 1'b1; bus.cpu_araddr_i = 32'h2010;
    #1 chk("t3_read_hit", bus.read_hit_o, 1);
    step();
    bus.cpu_rreq_i = 1'b0;
    chk("t3_rmask", bus.cpu_rmask_o, 32'hF000000F);
    chk("t3_count", bus.count_o, 1);
    chk("t3_mem_wstrb", bus.mem_wstrb_o, 32'hF000000F);
    drain(20);

    // Write to the in-flight line on its completion cycle
    wr(32'h3000, rand_line(), '1);
    step();
    step();
    d2 = rand_line();
    bus.mem_bvalid_i = 1'b1;
    wr(32'h3000, d2, '1);
    bus.mem_bvalid_i = 1'b0;
    chk("t4_count", bus.count_o, 1);
    chk("t4_gap", bus.mem_wen_o, 0);
    step();
    chk("t4_reissue", bus.mem_wen_o, 1);
    chk("t4_wdata", bus.mem_wdata_o, d2);
    drain(20);

    // Allocation at the wrap slot while the head retires
    do_reset();
    for (int i = 0; i < 7; i++) wr(32'h6000 + i * 32, rand_line(), '1);
    bus.mem_bvalid_i = 1'b1;
    wr(32'h60E0, rand_line(), '1);
    bus.mem_bvalid_i = 1'b0;
    chk("t5_count", bus.count_o, 7);
    step();
    chk("t5_next_head", bus.mem_awaddr_o, 32'h6020);
    drain(100);

    // Flush, then reset mid-transaction
    for (int i = 0; i < 3; i++) wr(32'h7000 + i * 32, rand_line(), '1);
    bus.flush_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ((mq.size() == 0) && !m_sending) break;
      bus.cpu_wreq_i = 1'b1; bus.cpu_awaddr_i = 32'h9000 + k * 32; bus.cpu_wstrb_i = '1;
      bus.mem_bvalid_i = m_sending;
      #1 chk("t6_flush_wready", bus.cpu_wready_o, 0);
      step();
    end
    quiet();
    chk("t6_idle", bus.idle_o, 1);
    bus.flush_i = 1'b0;
    wr(32'hA000, rand_line(), '1);
    wr(32'hA020, rand_line(), '1);
    chk("t6_sending", bus.mem_wen_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_wen", bus.mem_wen_o, 0);
    chk("t6_rst_count", bus.count_o, 0);

    // Random traffic over a small line pool to provoke hits, collisions and full/flush stalls
    for (int n = 0; n < 2000; n++) begin
      bus.cpu_wreq_i   = $urandom_range(0, 1);
      bus.cpu_awaddr_i = 32'h8000 + $urandom_range(0, 9) * 32 + $urandom_range(0, 31);
      bus.cpu_wdata_i  = rand_line();
      r = $urandom_range(0, 7);
      bus.cpu_wstrb_i  = (r == 0) ? '0 : (r == 1) ? '1 : SB'($urandom);
      bus.cpu_rreq_i   = $urandom_range(0, 1);
      bus.cpu_araddr_i = 32'h8000 + $urandom_range(0, 11) * 32 + $urandom_range(0, 31);
      if ($urandom_range(0, 49) == 0) bus.flush_i = !bus.flush_i;
      bus.mem_bvalid_i = m_sending && ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    bus.flush_i = 1'b0;
    quiet();
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
